// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
//   tx_state_t          transmitter FSM states
//   PAR_NONE/ODD/EVEN   encodings for the PARITY parameter
//   calc_clks_per_bit   system clocks per line bit (truncating divide)
package uart_tx_fifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int calc_clks_per_bit(input int clock_rate, input int baud_rate);
        return clock_rate / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-side bus of the UART transmitter.
//   txEn, txStart, in     producer -> transmitter (enable, write strobe, payload)
//   txReady, txBusy,
//   txDone, tx, fifoCount transmitter -> producer / line
// master: byte producer, slave: uart_tx_fifo.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                 txEn;
    logic                 txStart;
    logic [DATA_BITS-1:0] in;
    logic                 txReady;
    logic                 txBusy;
    logic                 txDone;
    logic                 tx;
    logic [CNT_W-1:0]     fifoCount;

    modport master (
        output txEn, txStart, in,
        input  txReady, txBusy, txDone, tx, fifoCount
    );

    modport slave (
        input  txEn, txStart, in,
        output txReady, txBusy, txDone, tx, fifoCount
    );
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO holding payload words waiting for transmission.
//   clk, res            clock, synchronous active-high reset
//   wr_en, wr_data      write request; ignored while full
//   rd_en, rd_data      read request; rd_data shows the head word combinationally
//   full, empty, count  occupancy status
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-fed UART transmitter with internal baud divider, configurable
// data width (5..9), parity (none/odd/even) and 1 or 2 stop bits.
//   clk, res   system clock, synchronous active-high reset
//   bus        uart_tx_fifo_if slave: producer handshake, status and tx line
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLOCK_RATE = 100000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input logic           clk,
    input logic           res,
    uart_tx_fifo_if.slave bus
);
    localparam int CLKS     = calc_clks_per_bit(CLOCK_RATE, BAUD_RATE);
    localparam int CNT_W    = (CLKS > 1) ? $clog2(CLKS) : 1;
    localparam int IDX_W    = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 bit_end;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rd;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .res     (res),
        .wr_en   (bus.txStart),
        .wr_data (bus.in),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (bus.fifoCount)
    );

    assign bit_end     = (cnt_q == CNT_LAST);
    assign bus.txReady = !fifo_full;
    assign bus.txBusy  = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        stop_d     = stop_q;
        shift_d    = shift_q;
        par_d      = par_q;
        pop        = 1'b0;
        bus.txDone = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.txEn && !fifo_empty) pop = 1'b1;
            end
            ST_START: begin
                if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop_q == STOP_LAST) begin
                        stop_d     = 1'b0;
                        bus.txDone = 1'b1;
                        // Chain straight into the next frame when more data is waiting.
                        if (bus.txEn && !fifo_empty) pop = 1'b1;
                        else                         state_d = ST_IDLE;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q != ST_IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;

        if (pop) begin
            state_d = ST_START;
            cnt_d   = '0;
            shift_d = fifo_rd;
            par_d   = (PARITY == PAR_EVEN) ? ^fifo_rd : ~^fifo_rd;
        end
    end

    always_comb begin
        case (state_q)
            ST_START:  bus.tx = 1'b0;
            ST_DATA:   bus.tx = shift_q[0];
            ST_PARITY: bus.tx = par_q;
            default:   bus.tx = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 16 clk/bit: 8N1, 8E1, 8O1 and 7N2 instances.
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    logic res = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int last_wait;

    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifa ();
    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ife ();
    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifo ();
    uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) ifs ();

    uart_tx_fifo #(.CLOCK_RATE(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (.clk(clk), .res(res), .bus(ifa));
    uart_tx_fifo #(.CLOCK_RATE(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (.clk(clk), .res(res), .bus(ife));
    uart_tx_fifo #(.CLOCK_RATE(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (.clk(clk), .res(res), .bus(ifo));
    uart_tx_fifo #(.CLOCK_RATE(16), .BAUD_RATE(1), .DATA_BITS(7), .PARITY(0),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (.clk(clk), .res(res), .bus(ifs));

    logic       tx_w    [4];
    logic       busy_w  [4];
    logic       done_w  [4];
    logic       ready_w [4];
    logic [2:0] cnt_w   [4];

    assign tx_w[0] = ifa.tx;  assign busy_w[0] = ifa.txBusy;  assign done_w[0] = ifa.txDone;
    assign tx_w[1] = ife.tx;  assign busy_w[1] = ife.txBusy;  assign done_w[1] = ife.txDone;
    assign tx_w[2] = ifo.tx;  assign busy_w[2] = ifo.txBusy;  assign done_w[2] = ifo.txDone;
    assign tx_w[3] = ifs.tx;  assign busy_w[3] = ifs.txBusy;  assign done_w[3] = ifs.txDone;
    assign ready_w[0] = ifa.txReady;  assign cnt_w[0] = ifa.fifoCount;
    assign ready_w[1] = ife.txReady;  assign cnt_w[1] = ife.fifoCount;
    assign ready_w[2] = ifo.txReady;  assign cnt_w[2] = ifo.fifoCount;
    assign ready_w[3] = ifs.txReady;  assign cnt_w[3] = ifs.fifoCount;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive(input int d, input logic en, input logic st, input logic [8:0] data);
        case (d)
            0: begin ifa.txEn = en; ifa.txStart = st; ifa.in = data[7:0]; end
            1: begin ife.txEn = en; ife.txStart = st; ife.in = data[7:0]; end
            2: begin ifo.txEn = en; ifo.txStart = st; ifo.in = data[7:0]; end
            default: begin ifs.txEn = en; ifs.txStart = st; ifs.in = data[6:0]; end
        endcase
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Waits for the start bit, then samples each bit mid-way and tracks busy/done.
    // Leaves the caller on the negedge just after the frame.
    task automatic run_frame(input int d, input string tag, input int nbits,
                             input logic [15:0] exp_bits, input logic exp_busy_after);
        int waited  = 0;
        int done_n  = 0;
        int done_at = -1;
        int busy_n  = 0;
        while (tx_w[d] !== 1'b0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        last_wait = waited;
        check({tag, "_start"}, tx_w[d], 0);
        if (tx_w[d] !== 1'b0) return;
        for (int c = 0; c < nbits * 16; c++) begin
            if (c % 16 == 8) check($sformatf("%s_bit%0d", tag, c / 16), tx_w[d], exp_bits[c / 16]);
            if (busy_w[d]) busy_n++;
            if (done_w[d]) begin
                done_n++;
                done_at = c;
            end
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, busy_n, nbits * 16);
        check({tag, "_done_count"}, done_n, 1);
        check({tag, "_done_at"}, done_at, nbits * 16 - 1);
        check({tag, "_busy_after"}, busy_w[d], exp_busy_after);
    endtask

    initial begin
        int done_n;
        int low_n;
        for (int d = 0; d < 4; d++) drive(d, 1'b0, 1'b0, 9'h0);
        step(3);
        res = 1'b0;
        step(1);

        check("rst_tx",    tx_w[0],    1);
        check("rst_busy",  busy_w[0],  0);
        check("rst_done",  done_w[0],  0);
        check("rst_ready", ready_w[0], 1);
        check("rst_count", cnt_w[0],   0);

        // 8N1, 0x41
        drive(0, 1'b1, 1'b1, 9'h41);
        step(1);
        drive(0, 1'b1, 1'b0, 9'h0);
        run_frame(0, "8n1", 10, 16'h0282, 1'b0);
        check("8n1_latency", last_wait, 1);
        check("8n1_count_end", cnt_w[0], 0);

        // Even and odd parity on 0x41
        drive(1, 1'b1, 1'b1, 9'h41);
        step(1);
        drive(1, 1'b1, 1'b0, 9'h0);
        run_frame(1, "8e1", 11, 16'h0482, 1'b0);

        drive(2, 1'b1, 1'b1, 9'h41);
        step(1);
        drive(2, 1'b1, 1'b0, 9'h0);
        run_frame(2, "8o1", 11, 16'h0682, 1'b0);

        // 7N2, 0x55
        drive(3, 1'b1, 1'b1, 9'h55);
        step(1);
        drive(3, 1'b1, 1'b0, 9'h0);
        run_frame(3, "7n2", 10, 16'h03AA, 1'b0);

        // Disabled: fill, overflow attempt, then enable for back-to-back frames
        drive(0, 1'b0, 1'b1, 9'h11); step(1);
        drive(0, 1'b0, 1'b1, 9'h22); step(1);
        drive(0, 1'b0, 1'b1, 9'h33); step(1);
        drive(0, 1'b0, 1'b1, 9'h44); step(1);
        check("fill_ready_full", ready_w[0], 0);
        drive(0, 1'b0, 1'b1, 9'h55); step(1);
        drive(0, 1'b0, 1'b0, 9'h0);
        check("fill_count", cnt_w[0], 4);
        check("fill_tx_idle", tx_w[0], 1);
        step(5);
        check("fill_tx_still_idle", tx_w[0], 1);
        drive(0, 1'b1, 1'b0, 9'h0);
        run_frame(0, "b2b0", 10, 16'h0222, 1'b1);
        run_frame(0, "b2b1", 10, 16'h0244, 1'b1);
        check("b2b1_no_gap", last_wait, 0);
        run_frame(0, "b2b2", 10, 16'h0266, 1'b1);
        check("b2b2_no_gap", last_wait, 0);
        run_frame(0, "b2b3", 10, 16'h0288, 1'b0);
        check("b2b3_no_gap", last_wait, 0);
        check("b2b_count_end", cnt_w[0], 0);
        step(40);
        check("b2b_fifth_not_sent", tx_w[0], 1);

        // Reset mid-frame with two words queued
        drive(0, 1'b1, 1'b1, 9'h5A); step(1);
        drive(0, 1'b1, 1'b1, 9'hA5); step(1);
        drive(0, 1'b1, 1'b1, 9'h3C); step(1);
        drive(0, 1'b1, 1'b0, 9'h0);
        check("rst_mid_count_pre", cnt_w[0], 2);
        step(16 * 3 + 4);
        check("rst_mid_busy_pre", busy_w[0], 1);
        res = 1'b1;
        step(1);
        res = 1'b0;
        check("rst_mid_tx",    tx_w[0],    1);
        check("rst_mid_busy",  busy_w[0],  0);
        check("rst_mid_count", cnt_w[0],   0);
        check("rst_mid_ready", ready_w[0], 1);
        done_n = 0;
        low_n  = 0;
        for (int i = 0; i < 200; i++) begin
            if (done_w[0]) done_n++;
            if (!tx_w[0])  low_n++;
            step(1);
        end
        check("rst_mid_no_done", done_n, 0);
        check("rst_mid_tx_quiet", low_n, 0);

        // Push while full in the same cycle as a pop
        drive(0, 1'b0, 1'b1, 9'h01); step(1);
        drive(0, 1'b0, 1'b1, 9'h02); step(1);
        drive(0, 1'b0, 1'b1, 9'h03); step(1);
        drive(0, 1'b0, 1'b1, 9'h04); step(1);
        check("pp_ready_full", ready_w[0], 0);
        check("pp_count_full", cnt_w[0], 4);
        drive(0, 1'b1, 1'b1, 9'h99); step(1);
        drive(0, 1'b1, 1'b0, 9'h0);
        check("pp_count_after", cnt_w[0], 3);
        run_frame(0, "pp0", 10, 16'h0202, 1'b1);
        run_frame(0, "pp1", 10, 16'h0204, 1'b1);
        run_frame(0, "pp2", 10, 16'h0206, 1'b1);
        run_frame(0, "pp3", 10, 16'h0208, 1'b0);
        step(40);
        check("pp_dropped_not_sent", tx_w[0], 1);
        check("pp_count_end", cnt_w[0], 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
